// File: rtl/ring_nic.sv
// Ring network interface: one-entry receive and transmit buffers bridging a processor port and a ring router.
// Optional macro RING_NIC_POLARITY_GATE_EN makes injection wait for the cycle whose polarity matches the VC bit.
module ring_nic #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di
);

    localparam logic [1:0] A_IN_BUF  = 2'b00;
    localparam logic [1:0] A_IN_STAT = 2'b01;
    localparam logic [1:0] A_OUT_BUF = 2'b10;
    localparam logic [1:0] A_OUT_STAT = 2'b11;

    logic [DATA_W-1:0] in_buf;
    logic [DATA_W-1:0] out_buf;
    logic              in_full;
    logic              out_full;
    logic              rd;
    logic              wr;
    logic              gate;

    assign rd = nicEn & ~nicWrEn;
    assign wr = nicEn & nicWrEn;

`ifdef RING_NIC_POLARITY_GATE_EN
    assign gate = (out_buf[0] == net_polarity);
`else
    assign gate = 1'b1;
`endif

    assign net_ri = ~in_full;
    assign net_do = out_buf;
    assign net_so = out_full & net_ro & gate;

    always_comb begin
        d_out = '0;
        if (rd) begin
            unique case (addr)
                A_IN_BUF:   d_out = in_buf;
                A_IN_STAT:  d_out = {{(DATA_W-1){1'b0}}, in_full};
                A_OUT_BUF:  d_out = '0;
                A_OUT_STAT: d_out = {{(DATA_W-1){1'b0}}, out_full};
                default:    d_out = '0;
            endcase
        end
    end

    // A clearing read and a network capture never coincide: net_ri is low while full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else if (rd && addr == A_IN_BUF && in_full) begin
            in_full <= 1'b0;
        end else if (net_si && net_ri) begin
            in_buf  <= net_di;
            in_full <= 1'b1;
        end
    end

    // A write in the same cycle as a send sees full status and is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else if (net_so) begin
            out_full <= 1'b0;
        end else if (wr && addr == A_OUT_BUF && !out_full) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ring_nic.sv
// Directed self-checking bench for ring_nic.
// Expectations follow RING_NIC_POLARITY_GATE_EN when the bench is built with it.
module tb_ring_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    int n_chk  = 0;
    int n_fail = 0;
    bit tog    = 1'b0;

    localparam logic [63:0] P  = 64'h0001_0001_0000_0002;
    localparam logic [63:0] PA = 64'h0000_00AA_0000_0000;
    localparam logic [63:0] PB = 64'h0000_00BB_0000_0004;
    localparam logic [63:0] PC = 64'h0000_00CC_0000_0008;
    localparam logic [63:0] R  = 64'h8000_0002_0003_0001;
    localparam logic [63:0] R2 = 64'h1234_5678_9ABC_DEF1;

    ring_nic #(.DATA_W(64)) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .d_in(d_in),
        .d_out(d_out),
        .nicEn(nicEn),
        .nicWrEn(nicWrEn),
        .net_so(net_so),
        .net_ro(net_ro),
        .net_do(net_do),
        .net_polarity(net_polarity),
        .net_si(net_si),
        .net_ri(net_ri),
        .net_di(net_di)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) net_polarity = ~net_polarity;
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1'b1;
        nicWrEn = 1'b0;
        addr = a;
        #1;
    endtask

    task automatic wr(input logic [63:0] v);
        nicEn = 1'b1;
        nicWrEn = 1'b1;
        addr = 2'b10;
        d_in = v;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        addr = 2'b00;
        d_in = '0;
        nicEn = 1'b0;
        nicWrEn = 1'b0;
        net_ro = 1'b0;
        net_polarity = 1'b0;
        net_si = 1'b0;
        net_di = '0;

        repeat (4) step();
        check("rst_ri", {63'd0, net_ri}, 64'd1);
        check("rst_so", {63'd0, net_so}, 64'd0);
        check("rst_do", net_do, 64'd0);
        rd(2'b00);
        check("rst_inbuf", d_out, 64'd0);
        reset = 1'b1;
        step();
        rd(2'b01);
        check("post_rst_in_stat", d_out, 64'd0);
        rd(2'b11);
        check("post_rst_out_stat", d_out, 64'd0);
        check("post_rst_ri", {63'd0, net_ri}, 64'd1);
        nicEn = 1'b0;
        #1;
        check("idle_dout", d_out, 64'd0);

        // write/send path with toggling polarity
        net_ro = 1'b1;
        net_polarity = 1'b0;
        tog = 1'b1;
        wr(P);
        check("wr_dout_zero", d_out, 64'd0);
        step();
        rd(2'b11);
        check("send_stat_full", d_out, 64'd1);
        check("send_do", net_do, P);
`ifdef RING_NIC_POLARITY_GATE_EN
        check("send_gated_odd", {63'd0, net_so}, 64'd0);
        step();
        check("send_pol0", {63'd0, net_so}, 64'd1);
        check("send_do2", net_do, P);
        check("send_stat_hold", d_out, 64'd1);
`else
        check("send_so", {63'd0, net_so}, 64'd1);
`endif
        step();
        check("send_so_done", {63'd0, net_so}, 64'd0);
        check("send_stat_clr", d_out, 64'd0);
        tog = 1'b0;
        net_polarity = 1'b0;

        // backpressure
        net_ro = 1'b0;
        wr(PA);
        step();
        check("bp_so_a", {63'd0, net_so}, 64'd0);
        wr(PB);
        step();
        rd(2'b11);
        check("bp_stat", d_out, 64'd1);
        check("bp_do_a", net_do, PA);
        check("bp_so_b", {63'd0, net_so}, 64'd0);
        step();
        check("bp_so_hold", {63'd0, net_so}, 64'd0);
        net_ro = 1'b1;
        #1;
        check("bp_so_rise", {63'd0, net_so}, 64'd1);
        check("bp_do_rise", net_do, PA);
        step();
        check("bp_stat_clr", d_out, 64'd0);
        check("bp_b_lost", net_do, PA);

        // write coinciding with a send is dropped
        wr(PB);
        step();
        check("coin_so", {63'd0, net_so}, 64'd1);
        wr(PC);
        step();
        rd(2'b11);
        check("coin_stat", d_out, 64'd0);
        check("coin_do", net_do, PB);
        net_ro = 1'b0;

        // receive path
        nicEn = 1'b0;
        net_si = 1'b1;
        net_di = R;
        #1;
        check("rx_ri_pre", {63'd0, net_ri}, 64'd1);
        step();
        net_si = 1'b0;
        check("rx_ri_low", {63'd0, net_ri}, 64'd0);
        rd(2'b01);
        check("rx_stat", d_out, 64'd1);
        net_si = 1'b1;
        net_di = R2;
        step();
        net_si = 1'b0;
        rd(2'b00);
        check("rx_no_overwrite", d_out, R);
        step();
        check("rx_ri_back", {63'd0, net_ri}, 64'd1);
        check("rx_empty_read", d_out, R);
        rd(2'b01);
        check("rx_stat_clr", d_out, 64'd0);
        step();
        check("rx_stat_stays", d_out, 64'd0);

        // reset with both buffers full
        wr(PA);
        net_si = 1'b1;
        net_di = R2;
        step();
        net_si = 1'b0;
        rd(2'b01);
        check("mid_in_full", d_out, 64'd1);
        rd(2'b11);
        check("mid_out_full", d_out, 64'd1);
        reset = 1'b0;
        #1;
        check("mid_out_clr", d_out, 64'd0);
        check("mid_ri", {63'd0, net_ri}, 64'd1);
        check("mid_do", net_do, 64'd0);
        rd(2'b01);
        check("mid_in_clr", d_out, 64'd0);
        rd(2'b00);
        check("mid_inbuf_clr", d_out, 64'd0);
        net_ro = 1'b1;
        #1;
        check("mid_so", {63'd0, net_so}, 64'd0);
        step();
        reset = 1'b1;
        nicEn = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_nic.md
RING_NIC -- requirements
Module: ring_nic

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning packet and processor data width; the packet field map in REQ-009 assumes 64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have processor-side ports:
- addr, input, 2 bits [0:1]: register select.
- d_in, input, DATA_W [0:63]: write data.
- d_out, output, DATA_W [0:63]: read data.
- nicEn, input, 1: access enable.
- nicWrEn, input, 1: 1 = write, 0 = read.
REQ-005 SHALL have router-side transmit ports:
- net_so, output, 1: send valid.
- net_ro, input, 1: router ready.
- net_do, output, DATA_W [0:63]: outgoing packet.
- net_polarity, input, 1: router even/odd cycle phase.
REQ-006 SHALL have router-side receive ports:
- net_si, input, 1: incoming valid.
- net_ri, output, 1: NIC ready.
- net_di, input, DATA_W [0:63]: incoming packet.

Function
REQ-007 SHALL decode addr as: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
REQ-008 SHALL hold state in four registers:
- one-entry input buffer in_buf plus flag in_full;
- one-entry output buffer out_buf plus flag out_full.
REQ-009 SHALL carry packets opaquely with this field map:
- bit 0: VC;
- bit 1: direction (0 = clockwise);
- bits 2:7: reserved;
- bits 8:15: hop count;
- bits 16:31: source;
- bits 32:63: payload.
REQ-010 SHALL drive d_out combinationally and only while nicEn=1 and nicWrEn=0; otherwise d_out = 0:
- addr 00: d_out = in_buf;
- addr 01: d_out = {63 zeros, in_full};
- addr 10: d_out = 0;
- addr 11: d_out = {63 zeros, out_full}.
REQ-011 SHALL, on a read of addr 00 with in_full=1, clear in_full at that clock edge; a read of addr 00 with in_full=0 returns in_buf unchanged and changes no state.
REQ-012 SHALL, on a write (nicEn=1, nicWrEn=1) to addr 10 with out_full=0, load d_in into out_buf and set out_full at that edge.
REQ-013 SHALL ignore writes to addr 10 while out_full=1, and SHALL ignore writes to addrs 00, 01 and 11.
REQ-014 SHALL drive net_ri = ~in_full combinationally.
REQ-015 SHALL, when net_si=1 and net_ri=1, capture net_di into in_buf and set in_full at that edge (one-cycle latency to status visibility).
REQ-016 SHALL drive net_do = out_buf at all times.
REQ-017 SHALL drive net_so = out_full AND net_ro AND gate, where gate is defined in REQ-025.
REQ-018 SHALL clear out_full at every edge where net_so=1 (one packet per cycle maximum).
REQ-019 SHALL, on a processor write to addr 10 in the same cycle that net_so=1, ignore the write, because the status sampled before the edge is full.
REQ-020 SHALL NOT allow a network capture and a clearing read to coincide; this is guaranteed by REQ-014, since net_ri=0 whenever in_full=1.
REQ-021 SHALL NOT modify any packet field; hop and direction handling belong to the router.

Reset
REQ-022 SHALL, while reset=0 and independent of clk, force in_full=0, out_full=0, in_buf=0 and out_buf=0.
REQ-023 SHALL therefore drive, during reset: net_so=0, net_ri=1, net_do=0, and d_out=0 for all register reads.
REQ-024 SHALL discard any packet that is mid-handshake when reset asserts; no partial state survives.

Configuration
REQ-025 SHALL support macro RING_NIC_POLARITY_GATE_EN:
- when defined, gate = (out_buf[0] == net_polarity), so a packet injects only in the cycle whose polarity matches its VC bit;
- when undefined, gate = 1 and polarity is ignored.

Verification
REQ-026 SHALL cover reset: hold reset=0 for 4 cycles, then release -> net_ri=1, net_so=0, and reads of addrs 01 and 11 return 0.
REQ-027 SHALL cover the write/send path with RING_NIC_POLARITY_GATE_EN defined:
- stimulus: write 64'h0001_0001_0000_0002 to addr 10, with net_ro=1 and net_polarity toggling;
- addr 11 reads 1 next cycle;
- net_so pulses once, on the first polarity=0 cycle, with net_do equal to the packet;
- addr 11 reads 0 afterwards.
REQ-028 SHALL cover backpressure:
- stimulus: hold net_ro=0 and write packet A, then packet B, to addr 10;
- out_full stays 1 and net_so stays 0;
- after net_ro rises, A is sent and B is lost.
REQ-029 SHALL cover the receive path:
- drive net_si=1 with net_di=64'h8000_0002_0003_0001;
- net_ri falls next cycle and addr 01 reads 1;
- reading addr 00 returns the packet and restores net_ri=1 next cycle;
- a second packet offered while full is not accepted.
REQ-030 SHALL cover reset mid-operation: assert reset with both buffers full -> both statuses 0 immediately, without waiting for a clock edge.
